// File: rtl/core_pool_assignment.sv
// Core pool allocator: bitmap of busy cores, offers one free core per cycle
// (round-robin or lowest-first), accepts out-of-order releases by ID.
module core_pool_assignment #(
    parameter  int CORES       = 4,
    parameter  int ROUND_ROBIN = 1,
    localparam int ID_W        = $clog2(CORES),
    localparam int CNT_W       = $clog2(CORES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    output logic              core_valid,
    output logic [ID_W-1:0]   core_id,
    input  logic              core_request,
    input  logic              core_release,
    input  logic [ID_W-1:0]   released_core_id,
    output logic [CORES-1:0]  busy_mask,
    output logic [CNT_W-1:0]  busy_count,
    output logic              release_error
);

    localparam int unsigned NC  = CORES;
    localparam int unsigned EXT = 1 << ID_W;

    logic [CORES-1:0] busy_q, busy_d;
    logic [ID_W-1:0]  rr_q, rr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic [EXT-1:0]   busy_ext, busy_ext_d;
    logic             found;
    logic [ID_W-1:0]  pick;
    logic             grant, rel_ok;
    int unsigned      idx;

    always_comb begin
        // IDs at or above CORES read as "not busy" for release but are never searched,
        // so out-of-range releases fall out as illegal and are never offered.
        busy_ext              = '0;
        busy_ext[CORES-1:0]   = busy_q;

        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int unsigned i = 0; i < NC; i++) begin
            idx = i;
            if (ROUND_ROBIN != 0) idx = idx + 32'(rr_q);
            if (idx >= NC) idx = idx - NC;
            if (!found && !busy_ext[ID_W'(idx)]) begin
                found = 1'b1;
                pick  = ID_W'(idx);
            end
        end

        grant  = found & core_request;
        rel_ok = core_release & busy_ext[released_core_id];

        busy_ext_d = busy_ext;
        if (grant)  busy_ext_d[pick]             = 1'b1;
        if (rel_ok) busy_ext_d[released_core_id] = 1'b0;
        busy_d = busy_ext_d[CORES-1:0];

        rr_d = rr_q;
        if (grant) rr_d = (32'(pick) == NC - 1) ? '0 : pick + ID_W'(1);

        cnt_d = cnt_q;
        case ({grant, rel_ok})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        err_d = core_release & ~rel_ok;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
            rr_q   <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            rr_q   <= rr_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign core_valid    = ~&busy_q;
    assign core_id       = core_valid ? pick : '0;
    assign busy_mask     = busy_q;
    assign busy_count    = cnt_q;
    assign release_error = err_q;

endmodule

// File: doc/core_pool_assignment.md
# core_pool_assignment

Parametrised successor to the in-order core allocator in the dispatch path. It tracks per-core busy state in a bitmap, so cores may be released in any order by ID. It offers a free core to the dispatcher through a level valid/request handshake, selected either round-robin or lowest-index-first. It also reports occupancy and flags illegal releases.

## Interface
Parameters:
- CORES, default 4: number of managed cores; legal range 2..256; need not be a power of 2.
- ROUND_ROBIN, default 1: 1 = search starts after the last granted ID; 0 = always search from ID 0.
- ID_W, derived as $clog2(CORES): core ID width; not overridable.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high.
- core_valid  out  1  a free core is being offered.
- core_id  out  ID_W  offered core; 0 when core_valid=0.
- core_request  in  1  level; a grant occurs on any cycle with core_valid & core_request.
- core_release  in  1  level; each high cycle releases released_core_id.
- released_core_id  in  ID_W  core being returned.
- busy_mask  out  CORES  bit i = core i allocated.
- busy_count  out  $clog2(CORES+1)  popcount of busy_mask.
- release_error  out  1  one-cycle pulse on an illegal release.

## Operation
- State: busy_mask register, rr_ptr register (ID_W), busy_count register, release_error register.
- Offer logic is combinational from registered state only; there is no input-to-output combinational path.
  - core_valid = (busy_mask != all-ones over CORES bits).
  - core_id = first clear bit of busy_mask.
  - ROUND_ROBIN=1: search order is rr_ptr, rr_ptr+1, … CORES-1, 0, … rr_ptr-1.
  - ROUND_ROBIN=0: search order is 0 upward.
- Grant (core_valid & core_request):
  - Set busy_mask[core_id].
  - rr_ptr <= core_id+1, wrapping to 0 when core_id = CORES-1.
  - rr_ptr is unchanged when there is no grant.
- Release (core_release=1): legal iff released_core_id < CORES and busy_mask[released_core_id]=1.
  - Legal: clear that bit.
  - Illegal: no state change except release_error <= 1 for one cycle.
- busy_count <= busy_count + grant − legal_release. It must always equal the popcount of busy_mask.
- core_request is level-sensitive. Holding it high grants one core per cycle while cores remain free.

## Timing
- Reset values: busy_mask=0, busy_count=0, rr_ptr=0, release_error=0. Outputs therefore reset to core_valid=1, core_id=0.
- Grant latency: the offered ID is valid in the request cycle. busy_mask and busy_count update at the next edge, and the next offer appears in the following cycle.
- Release latency: a released core is offerable in the cycle after core_release is sampled. It is never offered in the same cycle it is released.
- Simultaneous grant and legal release of a different ID: both apply at the same edge; busy_count is unchanged.
- Release of the ID being granted in the same cycle: that ID is free, so the release is illegal.
  - The grant proceeds.
  - release_error pulses.
  - The bit ends up set.
- Full (all CORES busy): core_valid=0, core_id=0, requests ignored, rr_ptr held.
  - A release while full makes core_valid=1 on the next cycle.
- Empty: busy_count=0. Releases are all illegal.
- Wrap-around: with rr_ptr=CORES-1, the search wraps to 0. The pointer wraps to 0 after granting CORES-1.
- Non-power-of-2 CORES: IDs ≥ CORES are never offered. Releasing them is illegal.
- Reset asserted mid-operation: all state returns to reset values at that edge, and the outputs follow. A request or release in the same cycle is ignored.

## Test plan
- Reset, then request held high 5 cycles, CORES=4, ROUND_ROBIN=1 -> grants 0,1,2,3. Cycle 5 has core_valid=0, busy_mask=4'b1111, busy_count=4.
- From full, release ID 2, then request -> core_valid=1 the cycle after the release, core_id=2 granted, busy_count 3 then 4.
- ROUND_ROBIN=1: grant 0,1, release 0, request -> core_id=2 (not 0). Same sequence with ROUND_ROBIN=0 -> core_id=0.
- Double release: release ID 1 while busy, then release 1 again -> first release clears bit 1. The second pulses release_error for exactly 1 cycle; busy_mask and busy_count are unchanged.
- CORES=5: release ID 6 -> release_error=1. Fill all 5 -> grants 0..4 and ID 5 is never offered. Simultaneous grant and release of a different ID -> busy_count unchanged.
- Reset asserted with 3 busy and request high -> next cycle busy_mask=0, busy_count=0, core_valid=1, core_id=0, no grant recorded.
